// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the dual-port BRAM round-robin arbiter.
// The port struct is sized for the 256x128 macro this block fronts.
package bram_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 128;
  localparam int ID_W_MAX   = 3;   // enough for up to 8 requesters

  typedef struct packed {
    logic                  en;
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } bram_port_t;

  typedef struct packed {
    logic                busy;
    logic [ID_W_MAX-1:0] id;
  } rsp_tag_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bram_rr_pick.sv
// Combinational circular find-first: first valid, unmasked index at or after ptr,
// wrapping modulo N.
module bram_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW:0] pos;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    // Walk from the far end back towards ptr so the nearest candidate is written last.
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (valid[pos[IW-1:0]] && !mask[pos[IW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/bram_dp_arbiter.sv
// Round-robin arbiter sharing one true-dual-port BRAM among NUM_REQ requesters.
// Optional macro BRAM_ARB_COLLISION_STALL_EN withholds port B on same-address hazards.
module bram_dp_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_rdata,
  output logic                      ena,
  output logic                      enb,
  output logic                      wea,
  output logic                      web,
  output logic [ADDR_W-1:0]         addra,
  output logic [ADDR_W-1:0]         addrb,
  output logic [DATA_W-1:0]         dia,
  output logic [DATA_W-1:0]         dib,
  input  logic [DATA_W-1:0]         doa,
  input  logic [DATA_W-1:0]         dob
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("bram_dp_arbiter: NUM_REQ must be in 2..8");
  end
  if (ADDR_W != ADDR_W_DEF || DATA_W != DATA_W_DEF) begin : g_bad_geometry
    $error("bram_dp_arbiter: ADDR_W/DATA_W must match the 256x128 macro");
  end

  logic [ID_W-1:0]    rr_ptr, wa, wb;
  logic               a_found, b_found, a_grant, b_grant;
  logic [NUM_REQ-1:0] b_mask;
  bram_port_t         port_a, port_b;
  rsp_tag_t           tag_a, tag_b;

  bram_rr_pick #(.N(NUM_REQ)) u_pick_a (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .mask  ('0),
    .found (a_found),
    .idx   (wa)
  );

  bram_rr_pick #(.N(NUM_REQ)) u_pick_b (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .mask  (b_mask),
    .found (b_found),
    .idx   (wb)
  );

  // Grants are gated with rst_n so the macro pins stay quiet while reset is held.
  always_comb begin
    b_mask     = '0;
    b_mask[wa] = 1'b1;
    a_grant    = rst_n & a_found;
    b_grant    = a_grant & b_found;
`ifdef BRAM_ARB_COLLISION_STALL_EN
    if (req_addr[wa*ADDR_W +: ADDR_W] == req_addr[wb*ADDR_W +: ADDR_W] &&
        (req_we[wa] | req_we[wb]))
      b_grant = 1'b0;
`endif
  end

  always_comb begin
    port_a    = '0;
    port_b    = '0;
    req_ready = '0;
    if (a_grant) begin
      port_a        = '{en: 1'b1, we: req_we[wa], addr: req_addr[wa*ADDR_W +: ADDR_W],
                        wdata: req_wdata[wa*DATA_W +: DATA_W]};
      req_ready[wa] = 1'b1;
    end
    if (b_grant) begin
      port_b        = '{en: 1'b1, we: req_we[wb], addr: req_addr[wb*ADDR_W +: ADDR_W],
                        wdata: req_wdata[wb*DATA_W +: DATA_W]};
      req_ready[wb] = 1'b1;
    end
  end

  assign ena   = port_a.en;
  assign wea   = port_a.we;
  assign addra = port_a.addr;
  assign dia   = port_a.wdata;
  assign enb   = port_b.en;
  assign web   = port_b.we;
  assign addrb = port_b.addr;
  assign dib   = port_b.wdata;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      tag_a  <= '0;
      tag_b  <= '0;
    end else begin
      if (a_grant) rr_ptr <= ID_W'(rr_next(b_grant ? int'(wb) : int'(wa), NUM_REQ));
      tag_a <= '{busy: a_grant & ~port_a.we, id: ID_W_MAX'(wa)};
      tag_b <= '{busy: b_grant & ~port_b.we, id: ID_W_MAX'(wb)};
    end
  end

  // Read data lands one cycle after issue in the slice of the requester that issued it.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_a.busy && tag_a.id == ID_W_MAX'(i)) begin
        rsp_valid[i]                  = 1'b1;
        rsp_rdata[i*DATA_W +: DATA_W] = doa;
      end
      if (tag_b.busy && tag_b.id == ID_W_MAX'(i)) begin
        rsp_valid[i]                  = 1'b1;
        rsp_rdata[i*DATA_W +: DATA_W] = dob;
      end
    end
  end

endmodule

// File: tb/tb_bram_dp_arbiter.sv
// Scoreboard bench for bram_dp_arbiter with a behavioural 256x128 dual-port BRAM.
module tb_bram_dp_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata, rsp_rdata;
  logic              ena, enb, wea, web;
  logic [AW-1:0]     addra, addrb;
  logic [DW-1:0]     dia, dib, doa, dob;

  always #5 clk = ~clk;

  bram_dp_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ena       (ena),
    .enb       (enb),
    .wea       (wea),
    .web       (web),
    .addra     (addra),
    .addrb     (addrb),
    .dia       (dia),
    .dib       (dib),
    .doa       (doa),
    .dob       (dob)
  );

  // Behavioural BRAM: registered read, one cycle latency, read-first.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ena) begin
      if (wea) mem[addra] <= dia;
      doa <= mem[addra];
    end
    if (enb) begin
      if (web) mem[addrb] <= dib;
      dob <= mem[addrb];
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          exp_q [N][$];
  logic [DW-1:0] shadow [256];
  logic [N-1:0]  pend_clear;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [7:0] b);
    return {16{b}};
  endfunction

  // Monitor: every presented response must match the oldest expectation for that requester.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("unexpected_rsp_req%0d", i), DW'(1), DW'(0));
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("rsp_data_req%0d", i), rsp_rdata[i*DW +: DW], e.data);
            check($sformatf("rsp_cycle_req%0d", i), DW'(cyc), DW'(e.due));
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Compare grants at the falling edge; queue expected read data for granted reads.
  task automatic grant(input string name, input logic [N-1:0] exp_ready, input bit push);
    @(negedge clk);
    check(name, DW'(req_ready), DW'(exp_ready));
    for (int i = 0; i < N; i++)
      if (exp_ready[i] && !req_we[i] && push)
        exp_q[i].push_back('{data: shadow[req_addr[i*AW +: AW]], due: cyc + 1});
    for (int i = 0; i < N; i++)
      if (exp_ready[i] && req_we[i])
        shadow[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
    pend_clear = exp_ready;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~pend_clear;
    pend_clear = '0;
  endtask

  task automatic step(input string name, input logic [N-1:0] exp_ready);
    grant(name, exp_ready, 1'b1);
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] fair_pat [4];
    fair_pat = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    pend_clear = '0;

    // Reset: outputs quiet even with requests pending.
    set_req(0, 1'b0, 8'h01, '0);
    set_req(3, 1'b1, 8'h02, pat(8'h33));
    @(negedge clk);
    check("reset_ctrl", DW'({req_ready, rsp_valid, ena, enb, wea, web, addra, addrb}), '0);
    check("reset_data", dia | dib | rsp_rdata[DW-1:0], '0);
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single write then read by requester 2 (rr_ptr 0 -> 3 -> 3).
    set_req(2, 1'b1, 8'h10, pat(8'hAA));
    grant("single_wr_ready", 4'b0100, 1'b1);
    check("single_wr_porta", DW'({ena, wea, addra}), DW'({1'b1, 1'b1, 8'h10}));
    check("single_wr_dia", dia, pat(8'hAA));
    check("single_wr_portb_idle", DW'({enb, web, addrb}) | dib, '0);
    advance();
    set_req(2, 1'b0, 8'h10, '0);
    grant("single_rd_ready", 4'b0100, 1'b1);
    check("single_rd_porta", DW'({ena, wea, addra}), DW'({1'b1, 1'b0, 8'h10}));
    advance();

    // Preload 0x20..0x23 with dual writes (rr_ptr 3 -> 2 -> 0).
    set_req(0, 1'b1, 8'h20, pat(8'hD0));
    set_req(1, 1'b1, 8'h21, pat(8'hD1));
    grant("preload01_ready", 4'b0011, 1'b1);
    check("preload01_portb", DW'({enb, web, addrb}), DW'({1'b1, 1'b1, 8'h21}));
    check("preload01_dib", dib, pat(8'hD1));
    advance();
    set_req(2, 1'b1, 8'h22, pat(8'hD2));
    set_req(3, 1'b1, 8'h23, pat(8'hD3));
    step("preload23_ready", 4'b1100);

    // Dual read issue from rr_ptr 0: A serves 0, B serves 1.
    set_req(0, 1'b0, 8'h20, '0);
    set_req(1, 1'b0, 8'h21, '0);
    grant("dual_ready", 4'b0011, 1'b1);
    check("dual_ports", DW'({ena, wea, addra, enb, web, addrb}),
          DW'({1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 8'h21}));
    advance();

    // rr_ptr is now 2: order 2,3,0,1 grants 2 (A) and 0 (B); 1 waits and is served next.
    set_req(0, 1'b0, 8'h22, '0);
    set_req(1, 1'b0, 8'h23, '0);
    set_req(2, 1'b0, 8'h21, '0);
    step("ptr2_ready", 4'b0101);
    step("held_req1_ready", 4'b0010);

    // Back-to-back reads by one requester: one response per cycle, in order.
    set_req(1, 1'b0, 8'h20, '0);
    step("b2b0_ready", 4'b0010);
    set_req(1, 1'b0, 8'h21, '0);
    step("b2b1_ready", 4'b0010);
    set_req(1, 1'b0, 8'h22, '0);
    step("b2b2_ready", 4'b0010);

    // Reset asserted while a read is in flight: the response is dropped.
    set_req(3, 1'b0, 8'h23, '0);
    grant("midflight_ready", 4'b1000, 1'b0);
    advance();
    rst_n = 1'b0;
    @(negedge clk);
    check("midflight_rsp_dropped", DW'(rsp_valid), '0);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'h40, pat(8'h11));
    #1;
    check("midflight_reset_outputs", DW'({req_ready, ena, enb, wea, web, addra, addrb}) | dia | dib, '0);
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle: nothing enabled, nothing returned, pointer left alone.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("idle%0d", k), DW'({ena, enb, rsp_valid}), '0);
      @(posedge clk);
      #1;
    end

    // Fairness from rr_ptr 0 with all four holding reads.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i]) set_req(i, 1'b0, 8'(8'h20 + i), '0);
      step($sformatf("fair%0d_ready", k), fair_pat[k]);
    end
    req_valid = '0;

`ifdef BRAM_ARB_COLLISION_STALL_EN
    // Write/read to the same address: B withheld, reader wins A next cycle with new data.
    set_req(0, 1'b1, 8'h05, pat(8'hE5));
    set_req(1, 1'b0, 8'h05, '0);
    step("collision_stall_ready", 4'b0001);
    step("collision_retry_ready", 4'b0010);
`else
    // Same-address writes are both issued; stored data is not examined.
    set_req(0, 1'b1, 8'h05, pat(8'hE5));
    set_req(1, 1'b1, 8'h05, pat(8'hE6));
    step("collision_both_ready", 4'b0011);
`endif

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      check($sformatf("drain_req%0d", i), DW'(exp_q[i].size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
